// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the burst master: transfer types, burst
// codes, fixed sideband values and the burst-length helper.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_SEQ,
        ST_LAST,
        ST_ERR
    } mst_state_e;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    localparam logic [2:0] HSIZE_WORD    = 3'd2;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    // Unsupported codes (including plain INCR) collapse to a single beat.
    function automatic logic [4:0] beats_of(input logic [2:0] burst);
        case (burst)
            HBURST_INCR4:  beats_of = 5'd4;
            HBURST_INCR8:  beats_of = 5'd8;
            HBURST_INCR16: beats_of = 5'd16;
            default:       beats_of = 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst initiator: SINGLE/INCR4/INCR8/INCR16 with wait states, ERROR
// termination and 1 KB splitting. Define AHB_M_BUSY_EN to add wr_avail_i/BUSY.
module ahb_burst_master
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [2:0]        cmd_burst_i,
    input  logic [DATA_W-1:0] wr_data_i,
`ifdef AHB_M_BUSY_EN
    input  logic              wr_avail_i,
`endif
    output logic              wr_pop_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] haddr,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [1:0]        htrans,
    output logic [3:0]        hprot,
    output logic              hmastlock,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hready,
    input  logic              hresp
);

    mst_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [4:0]        remain_q, remain_d;
    logic              write_q, write_d;
    logic [2:0]        burst_q, burst_d;
    logic              split_q, split_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    htrans_e           htrans_c;
    logic [2:0]        hburst_c;
    logic              at_boundary;
    logic              busy;
    logic              addr_done;
    logic              data_done;
    logic              err_start;

    assign at_boundary = (addr_q[9:0] == 10'd0);

`ifdef AHB_M_BUSY_EN
    assign busy = (state_q == ST_SEQ) && write_q && !at_boundary && !wr_avail_i;
`else
    assign busy = 1'b0;
`endif

    assign addr_done = hready && ((state_q == ST_ADDR) || ((state_q == ST_SEQ) && !busy));
    assign data_done = hready && !hresp && pend_q &&
                       ((state_q == ST_SEQ) || (state_q == ST_LAST));
    assign err_start = pend_q && hresp && !hready &&
                       ((state_q == ST_SEQ) || (state_q == ST_LAST));

    // Once a beat lands on a 1 KB boundary the rest of the burst is undefined-length INCR.
    always_comb begin
        htrans_c = HTRANS_IDLE;
        hburst_c = burst_q;
        case (state_q)
            ST_ADDR: htrans_c = HTRANS_NONSEQ;
            ST_SEQ: begin
                if (busy)
                    htrans_c = HTRANS_BUSY;
                else if (at_boundary)
                    htrans_c = HTRANS_NONSEQ;
                else
                    htrans_c = HTRANS_SEQ;
            end
            default: htrans_c = HTRANS_IDLE;
        endcase
        if (split_q || ((state_q == ST_SEQ) && at_boundary))
            hburst_c = HBURST_INCR;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        write_d    = write_q;
        burst_d    = burst_q;
        split_d    = split_q;
        pend_d     = pend_q;
        hwdata_d   = hwdata_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if (data_done && !write_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = hrdata;
        end
        if (hready && ((state_q == ST_SEQ) || (state_q == ST_LAST)))
            pend_d = 1'b0;
        if (addr_done) begin
            pend_d   = 1'b1;
            addr_d   = addr_q + ADDR_W'(4);
            remain_d = remain_q - 5'd1;
            if (write_q)
                hwdata_d = wr_data_i;
            if ((state_q == ST_SEQ) && at_boundary)
                split_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    state_d  = ST_ADDR;
                    addr_d   = cmd_addr_i & ~ADDR_W'(3);
                    write_d  = cmd_write_i;
                    remain_d = beats_of(cmd_burst_i);
                    burst_d  = (beats_of(cmd_burst_i) == 5'd1) ? HBURST_SINGLE : cmd_burst_i;
                    split_d  = 1'b0;
                    pend_d   = 1'b0;
                end
            end
            ST_ADDR: begin
                if (addr_done)
                    state_d = (remain_q == 5'd1) ? ST_LAST : ST_SEQ;
            end
            ST_SEQ: begin
                if (err_start)
                    state_d = ST_ERR;
                else if (addr_done && (remain_q == 5'd1))
                    state_d = ST_LAST;
            end
            ST_LAST: begin
                if (err_start) begin
                    state_d = ST_ERR;
                end else if (hready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_ERR: begin
                if (hready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    pend_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            write_q    <= 1'b0;
            burst_q    <= HBURST_SINGLE;
            split_q    <= 1'b0;
            pend_q     <= 1'b0;
            hwdata_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            write_q    <= write_d;
            burst_q    <= burst_d;
            split_q    <= split_d;
            pend_q     <= pend_d;
            hwdata_q   <= hwdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // The requester may only start again once the completion pulse has been seen.
    assign cmd_ready_o = (state_q == ST_IDLE) && !done_q;
    assign wr_pop_o    = addr_done && write_q;
    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign haddr       = addr_q;
    assign hwrite      = write_q;
    assign hsize       = HSIZE_WORD;
    assign hburst      = hburst_c;
    assign htrans      = htrans_c;
    assign hprot       = HPROT_DEFAULT;
    assign hmastlock   = 1'b0;
    assign hwdata      = hwdata_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Randomized self-checking bench for ahb_burst_master: a behavioural AHB slave
// plus a burst-level reference model of the expected bus beats and responses.
module tb_ahb_burst_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [31:0] cmd_addr_i;
    logic [2:0]  cmd_burst_i;
    logic [31:0] wr_data_i;
    logic        wr_pop_o;
    logic [31:0] rd_data_o;
    logic        rd_valid_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [1:0]  htrans;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
`ifdef AHB_M_BUSY_EN
    logic        wr_avail_i = 1'b1;
`endif

    ahb_burst_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_burst_i(cmd_burst_i), .wr_data_i(wr_data_i),
`ifdef AHB_M_BUSY_EN
        .wr_avail_i(wr_avail_i),
`endif
        .wr_pop_o(wr_pop_o), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .done_o(done_o), .err_o(err_o), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .htrans(htrans), .hprot(hprot), .hmastlock(hmastlock),
        .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    always #5 clk = ~clk;

    int testCount = 0;
    int failCount = 0;
    int cycle     = 0;

    // Slave-side and observation state, all owned by the single stimulus process.
    logic        prevHready, prevHresp, prevHwrite;
    logic [1:0]  prevHtrans;
    logic [31:0] prevHaddr, prevHwdata;
    logic [2:0]  prevHburst;
    logic        dpActive, dpWrite, errSecond, pendingCmd;
    logic [31:0] dpAddr;
    int          dpBeat, beatCount, stallLeft;
    int          errBeat, stallBeat, stallCycles, waitPct;
    int          popCount, doneCount, acceptCycle, firstAddrCycle, doneCycle;
    logic        errSeen;
    logic [31:0] wrData [16];
    logic [31:0] cmdAddr;
    logic [2:0]  cmdCode;
    logic        cmdWrite;
    logic [31:0] obsAddr[$];
    logic [1:0]  obsTrans[$];
    logic [2:0]  obsBurst[$];
    logic [31:0] obsWrData[$];
    logic [31:0] obsWrAddr[$];
    logic [31:0] obsRd[$];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] memFn(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    function automatic int beatsFor(input logic [2:0] code);
        if (code == 3'd3) return 4;
        if (code == 3'd5) return 8;
        if (code == 3'd7) return 16;
        return 1;
    endfunction

    task automatic clearSlave();
        prevHready = 1'b1; prevHresp = 1'b0; prevHtrans = 2'd0; prevHwrite = 1'b0;
        prevHaddr = '0; prevHwdata = '0; prevHburst = '0;
        dpActive = 1'b0; dpWrite = 1'b0; dpAddr = '0; dpBeat = 0;
        errSecond = 1'b0; stallLeft = 0;
    endtask

    // One bus cycle: resolve the edge just passed, then drive this cycle's slave response.
    task automatic stepCycle();
        @(negedge clk);
        cycle++;
        if (prevHready) begin
            if (dpActive && dpWrite && !prevHresp) begin
                obsWrData.push_back(prevHwdata);
                obsWrAddr.push_back(dpAddr);
            end
            if (prevHtrans == 2'd2 || prevHtrans == 2'd3) begin
                dpActive = 1'b1; dpWrite = prevHwrite; dpAddr = prevHaddr;
                beatCount++; dpBeat = beatCount;
                if (beatCount == 1) firstAddrCycle = cycle - 1;
                obsAddr.push_back(prevHaddr);
                obsTrans.push_back(prevHtrans);
                obsBurst.push_back(prevHburst);
                if (dpBeat == stallBeat) stallLeft = stallCycles;
            end else begin
                dpActive = 1'b0;
            end
        end else if (prevHresp) begin
            checkOutput("errIdle", {30'd0, htrans}, 32'd0);
        end else if (prevHtrans != 2'd0) begin
            checkOutput("holdAddr", haddr, prevHaddr);
            checkOutput("holdTrans", {30'd0, htrans}, {30'd0, prevHtrans});
            checkOutput("holdBurst", {29'd0, hburst}, {29'd0, prevHburst});
            checkOutput("holdWdata", hwdata, prevHwdata);
        end
        if (rd_valid_o) obsRd.push_back(rd_data_o);
        if (done_o) begin
            doneCount++; doneCycle = cycle; errSeen = err_o;
            checkOutput("rdyDone", {31'd0, cmd_ready_o}, 32'd0);
        end
        if (pendingCmd && cmd_ready_o) begin
            cmd_valid_i = 1'b1; cmd_addr_i = cmdAddr; cmd_burst_i = cmdCode;
            cmd_write_i = cmdWrite; acceptCycle = cycle; pendingCmd = 1'b0;
        end else begin
            cmd_valid_i = 1'b0;
        end
        hresp = 1'b0;
        hrdata = 32'hDEAD_BEEF;
        if (errSecond) begin
            hready = 1'b1; hresp = 1'b1; errSecond = 1'b0;
        end else if (dpActive && dpBeat == errBeat) begin
            hready = 1'b0; hresp = 1'b1; errSecond = 1'b1;
        end else if (stallLeft > 0) begin
            hready = 1'b0; stallLeft--;
        end else begin
            hready = ($urandom_range(0, 99) >= waitPct);
        end
        if (dpActive && !dpWrite) hrdata = memFn(dpAddr);
        wr_data_i = (popCount < 16) ? wrData[popCount] : 32'h0;
        #1;
        if (wr_pop_o) popCount++;
        prevHready = hready; prevHresp = hresp; prevHtrans = htrans; prevHaddr = haddr;
        prevHburst = hburst; prevHwrite = hwrite; prevHwdata = hwdata;
    endtask

    task automatic startCommand(input logic [31:0] addr, input logic [2:0] code, input logic wr,
                                input int eb, input int wp, input int sb, input int sc, input bit fixedData);
        for (int i = 0; i < 16; i++) wrData[i] = fixedData ? 32'(8'h11 * (i + 1)) : $urandom;
        cmdAddr = addr; cmdCode = code; cmdWrite = wr;
        errBeat = eb; waitPct = wp; stallBeat = sb; stallCycles = sc;
        obsAddr.delete(); obsTrans.delete(); obsBurst.delete();
        obsWrData.delete(); obsWrAddr.delete(); obsRd.delete();
        popCount = 0; doneCount = 0; beatCount = 0; errSeen = 1'b0;
        acceptCycle = -1; firstAddrCycle = -1; doneCycle = -1;
        pendingCmd = 1'b1;
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] code, input logic wr,
                                 input int eb, input int wp, input int sb, input int sc, input bit fixedData);
        int n, nAddr, nData, nb, expT, expB;
        bit crossed;
        logic [31:0] a;
        startCommand(addr, code, wr, eb, wp, sb, sc, fixedData);
        for (int t = 0; t < 600 && doneCount == 0; t++) stepCycle();
        if (doneCount == 0) begin
            checkOutput("timeout", 32'd0, 32'd1);
            return;
        end
        stepCycle();
        checkOutput("rdyAfter", {31'd0, cmd_ready_o}, 32'd1);

        n = beatsFor(code);
        nb = (n == 1) ? 0 : int'(code);
        nAddr = (eb != 0) ? eb : n;
        nData = (eb != 0) ? eb - 1 : n;
        checkOutput("nAddr", obsAddr.size(), nAddr);
        crossed = 1'b0;
        for (int i = 0; i < nAddr && i < obsAddr.size(); i++) begin
            a = addr + 32'(4 * i);
            if (i > 0 && a[9:0] == 10'd0) crossed = 1'b1;
            expT = (i == 0 || a[9:0] == 10'd0) ? 2 : 3;
            expB = (i > 0 && crossed) ? 1 : nb;
            checkOutput("beatAddr", obsAddr[i], a);
            checkOutput("beatTrans", {30'd0, obsTrans[i]}, 32'(expT));
            checkOutput("beatBurst", {29'd0, obsBurst[i]}, 32'(expB));
        end
        checkOutput("pops", popCount, wr ? nAddr : 0);
        checkOutput("nWrites", obsWrData.size(), wr ? nData : 0);
        for (int i = 0; i < obsWrData.size() && i < nData; i++) begin
            checkOutput("wrData", obsWrData[i], wrData[i]);
            checkOutput("wrAddr", obsWrAddr[i], addr + 32'(4 * i));
        end
        checkOutput("nReads", obsRd.size(), wr ? 0 : nData);
        for (int i = 0; i < obsRd.size() && i < nData; i++)
            checkOutput("rdData", obsRd[i], memFn(addr + 32'(4 * i)));
        checkOutput("doneCount", doneCount, 1);
        checkOutput("errFlag", {31'd0, errSeen}, (eb != 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        logic [2:0]  rcode;
        logic [31:0] raddr;
        int          rn, reb;

        reset = 1'b1; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0;
        cmd_burst_i = '0; wr_data_i = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
        pendingCmd = 1'b0; errBeat = 0; stallBeat = 0; stallCycles = 0; waitPct = 0;
        popCount = 0; doneCount = 0; beatCount = 0;
        clearSlave();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstHtrans", {30'd0, htrans}, 32'd0);
        checkOutput("rstHaddr", haddr, 32'd0);
        checkOutput("rstHwrite", {31'd0, hwrite}, 32'd0);
        checkOutput("rstHburst", {29'd0, hburst}, 32'd0);
        checkOutput("rstHsize", {29'd0, hsize}, 32'd2);
        checkOutput("rstHwdata", hwdata, 32'd0);
        checkOutput("rstRdData", rd_data_o, 32'd0);
        checkOutput("rstStrobes", {28'd0, rd_valid_o, done_o, err_o, wr_pop_o}, 32'd0);
        checkOutput("rstReady", {31'd0, cmd_ready_o}, 32'd1);
        checkOutput("hprot", {28'd0, hprot}, 32'h3);
        checkOutput("hmastlock", {31'd0, hmastlock}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] INCR4 write at 0x40, zero wait");
        applyStimulus(32'h40, 3'd3, 1'b1, 0, 0, 0, 0, 1'b1);
        checkOutput("nonseqCycle", 32'(firstAddrCycle - acceptCycle), 32'd1);
        checkOutput("doneCycle", 32'(doneCycle - acceptCycle), 32'd6);

        $display("[TB] INCR8 read at 0x80, 2 wait states on beat 3");
        applyStimulus(32'h80, 3'd5, 1'b0, 0, 0, 3, 2, 1'b0);

        $display("[TB] INCR16 write across 1 KB boundary");
        applyStimulus(32'h3F8, 3'd7, 1'b1, 0, 0, 0, 0, 1'b0);

        $display("[TB] INCR8 read with ERROR on beat 4");
        applyStimulus(32'h100, 3'd5, 1'b0, 4, 0, 0, 0, 1'b0);

        $display("[TB] randomized commands");
        for (int t = 0; t < 40; t++) begin
            rcode = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0)
                raddr = 32'(32'h400 * $urandom_range(1, 8) - 4 * $urandom_range(1, 10));
            else
                raddr = 32'($urandom_range(0, 4095) * 4);
            rn = beatsFor(rcode);
            reb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, rn)) : 0;
            applyStimulus(raddr, rcode, 1'($urandom_range(0, 1)), reb,
                          int'($urandom_range(0, 40)), 0, 0, 1'b0);
        end

        $display("[TB] reset mid INCR16");
        startCommand(32'h200, 3'd7, 1'b1, 0, 0, 0, 0, 1'b0);
        repeat (6) stepCycle();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rstMidHtrans", {30'd0, htrans}, 32'd0);
        checkOutput("rstMidReady", {31'd0, cmd_ready_o}, 32'd1);
        checkOutput("rstMidHaddr", haddr, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clearSlave();
        pendingCmd = 1'b0;
        doneCount = 0;
        repeat (5) stepCycle();
        checkOutput("rstNoDone", doneCount, 32'd0);
        checkOutput("rstIdle", {30'd0, htrans}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/ahb_burst_master.md
# ahb_burst_master

AHB-Lite initiator that turns single-command burst requests from local logic into protocol-correct AHB transfers (SINGLE, INCR4, INCR8, INCR16) on the same bus our AHB slave memory serves. It owns address/data-phase pipelining, wait-state stalls, ERROR termination and 1 KB boundary splitting, and returns read data and completion status to the requester.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; hsize fixed to 3'd2 (word)
- clk  in  1  bus clock
- reset  in  1  reset, asynchronous, active-high
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  master idle, accepts command
- cmd_write_i  in  1  1 = write burst
- cmd_addr_i  in  ADDR_W  start address, word aligned (bits[1:0] ignored, forced 0)
- cmd_burst_i  in  3  0 SINGLE, 3 INCR4, 5 INCR8, 7 INCR16; other codes treated as SINGLE
- wr_data_i  in  DATA_W  next write beat, valid whenever wr_pop_o=1
- wr_pop_o  out  1  write beat consumed this edge
- rd_data_o  out  DATA_W  registered read beat
- rd_valid_o  out  1  rd_data_o valid, one pulse per beat
- done_o  out  1  one-cycle pulse at command end
- err_o  out  1  with done_o: burst terminated by ERROR
- haddr  out  ADDR_W; hwrite out 1; hsize out 3; hburst out 3; htrans out 2; hprot out 4 (constant 4'b0011); hmastlock out 1 (constant 0); hwdata out DATA_W
- hrdata  in  DATA_W; hready  in  1; hresp  in  1

## Operation
- States: IDLE, ADDR (NONSEQ beat), SEQ (beats 2..N), LAST (final data phase, htrans=IDLE), ERR (second ERROR cycle).
- IDLE: cmd_ready_o=1; on cmd_valid_i latch command, beat count = 1/4/8/16, go ADDR.
- A beat's address phase completes on an edge with hready=1; then address += 4, remaining beats -1.
- Writes: wr_pop_o=1 in each cycle where an address phase completes; wr_data_i registered to hwdata, held through its data phase.
- Reads: data phase completing with hready=1, hresp=0 → rd_data_o<=hrdata, rd_valid_o=1 next cycle.
- After last address phase → LAST, htrans=IDLE; data phase completes → done_o next cycle, back to IDLE.
- 1 KB boundary: when next address has bits[9:0]=0 mid-burst, that beat is NONSEQ with hburst=1 (INCR) for the remainder.
- ERROR: hresp=1 with hready=0 → next cycle htrans=IDLE (ERR); remaining beats cancelled, no further wr_pop_o/rd_valid_o; done_o=err_o=1 after the second ERROR cycle.
- reset mid-burst: immediate return to IDLE, no done_o.

## Timing
- Reset values: htrans=0, haddr=0, hwrite=0, hburst=0, hsize=3'd2, hwdata=0, rd_data_o=0, all strobes 0, cmd_ready_o=1.
- Command accepted edge N → NONSEQ in cycle N+1; zero-wait INCR4: SEQ N+2..N+4, IDLE N+5, done_o in N+6.
- hready=0: haddr, htrans, hburst, hwrite, hwdata held unchanged; no pops.
- cmd_ready_o=0 from acceptance until cycle after done_o; no command overlap.

## Configuration
- AHB_M_BUSY_EN defined: extra input wr_avail_i (1); for write beats 2..N, if wr_avail_i=0 master drives htrans=BUSY with next-beat address, no pop, resumes SEQ when wr_avail_i=1. Not defined: port absent, wr_data_i always available, BUSY never issued.

## Structure
- ahb_pkg: htrans_e (IDLE 0, BUSY 1, NONSEQ 2, SEQ 3), hburst codes, HSIZE_WORD, HPROT_DEFAULT, beats_of(hburst) function.
- Single module; no sub-module needed.

## Test plan
- INCR4 write at 0x40, data 0x11..0x44, zero wait → NONSEQ/SEQ×3 at 0x40..0x4C, hwdata 0x11..0x44 one cycle behind, done_o N+6, err_o=0.
- INCR8 read at 0x80, hready low 2 cycles on beat 3 → address/htrans held, 8 rd_valid_o pulses in order.
- INCR16 write at 0x3F8 → beats 0x3F8,0x3FC SEQ path; 0x400 NONSEQ, hburst=1; 16 pops total.
- INCR8 read, ERROR on beat 4 → htrans=IDLE next cycle, 3 rd_valid_o, done_o=err_o=1.
- reset asserted mid INCR16 → htrans=0 same cycle, cmd_ready_o=1, no done_o.
- With AHB_M_BUSY_EN, wr_avail_i low 3 cycles at beat 2 → 3 BUSY cycles, address 0x44 held, then SEQ resumes.
